// File: rtl/hwag_event_scheduler.sv
// ---------------------------------------------------------------------------
// hwag_event_scheduler
//
// Angle-driven output scheduler for the hardware angle generator. Each of
// NCH channels has an on-angle and an off-angle. While the engine is
// synchronised, a scan index visits one channel per clock. The visited
// channel's two-state FSM is compared against the current crank angle.
// Angles and the enable mask are written into shadow registers. The shadows
// are copied into the active set at each angle wrap, and on every clock
// while the engine is not synchronised.
//
// Optional feature: define HWAG_SCHED_IRQ_EN to build the event pulse on
// evt_if. Without it, evt_if is tied to 0.
//
// Parameters
//   NCH        number of output channels (2..8)
//   AW         angle width; legal angles are 0..3839
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active low
//   hwag_start engine synchronised; 0 stops scanning and forces all channels off
//   acnt       current crank angle
//   acnt_e_top one-cycle pulse at the angle wrap (3839 -> 0)
//   we         configuration write strobe
//   addr       configuration address: 2k on-angle, 2k+1 off-angle, 16 enable mask
//   wdata      configuration write data
//   ch_out     channel drive outputs (registered FSM state)
//   evt_if     one-clock pulse after angle-match transitions (optional)
// ---------------------------------------------------------------------------
module hwag_event_scheduler #(
    parameter int NCH = 4,
    parameter int AW  = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hwag_start,
    input  logic [AW-1:0]  acnt,
    input  logic           acnt_e_top,
    input  logic           we,
    input  logic [4:0]     addr,
    input  logic [15:0]    wdata,
    output logic [NCH-1:0] ch_out,
    output logic           evt_if
);

    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    // Largest angle that can ever match; larger stored values stay inert.
    localparam logic [AW-1:0] ANG_MAX = AW'(3839);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    logic [AW-1:0]  r_sh_on  [NCH];
    logic [AW-1:0]  r_sh_off [NCH];
    logic [AW-1:0]  r_on     [NCH];
    logic [AW-1:0]  r_off    [NCH];
    logic [NCH-1:0] r_sh_mask;
    logic [NCH-1:0] r_mask;
    logic [SW-1:0]  r_scan;
    state_t         r_state     [NCH];
    state_t         w_state_nxt [NCH];
    logic           w_copy;
    logic           w_evt_now;
    logic           w_unused_wdata;

    // Upper wdata bits are architecturally don't-care.
    assign w_unused_wdata = ^wdata;

    assign w_copy = acnt_e_top | ~hwag_start;

    // Shadow and active configuration. The active set samples the shadow
    // value from before this clock, so a write on a copy clock waits for
    // the next copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                r_sh_on[k]  <= '0;
                r_sh_off[k] <= '0;
                r_on[k]     <= '0;
                r_off[k]    <= '0;
            end
            r_sh_mask <= '0;
            r_mask    <= '0;
        end else begin
            if (we) begin
                for (int k = 0; k < NCH; k++) begin
                    if (addr == 5'(2 * k))
                        r_sh_on[k] <= wdata[AW-1:0];
                    if (addr == 5'(2 * k + 1))
                        r_sh_off[k] <= wdata[AW-1:0];
                end
                if (addr == 5'd16)
                    r_sh_mask <= wdata[NCH-1:0];
            end
            if (w_copy) begin
                for (int k = 0; k < NCH; k++) begin
                    r_on[k]  <= r_sh_on[k];
                    r_off[k] <= r_sh_off[k];
                end
                r_mask <= r_sh_mask;
            end
        end
    end

    // Scan index: one channel per clock while synchronised, parked at 0 otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_scan <= '0;
        else if (!hwag_start)
            r_scan <= '0;
        else if (r_scan == SW'(NCH - 1))
            r_scan <= '0;
        else
            r_scan <= r_scan + 1'b1;
    end

    // Channel FSM state registers; their value is the channel output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++)
                r_state[k] <= ST_OFF;
        end else begin
            for (int k = 0; k < NCH; k++)
                r_state[k] <= w_state_nxt[k];
        end
    end

    // Next-state logic. Only the scanned channel can move on an angle match.
    // Equal on/off angles never turn a channel on. A cleared enable bit drops
    // the channel when it is next scanned, and it does not count as an event.
    always_comb begin
        w_evt_now = 1'b0;
        for (int k = 0; k < NCH; k++)
            w_state_nxt[k] = r_state[k];
        if (!hwag_start) begin
            for (int k = 0; k < NCH; k++)
                w_state_nxt[k] = ST_OFF;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (r_scan == SW'(k)) begin
                    case (r_state[k])
                        ST_OFF: begin
                            if (r_mask[k] && (acnt == r_on[k]) &&
                                (r_on[k] != r_off[k]) && (r_on[k] <= ANG_MAX)) begin
                                w_state_nxt[k] = ST_ON;
                                w_evt_now      = 1'b1;
                            end
                        end
                        ST_ON: begin
                            if (!r_mask[k]) begin
                                w_state_nxt[k] = ST_OFF;
                            end else if ((acnt == r_off[k]) && (r_off[k] <= ANG_MAX)) begin
                                w_state_nxt[k] = ST_OFF;
                                w_evt_now      = 1'b1;
                            end
                        end
                        default: w_state_nxt[k] = ST_OFF;
                    endcase
                end
            end
        end
    end

    always_comb begin
        ch_out = '0;
        for (int k = 0; k < NCH; k++)
            ch_out[k] = (r_state[k] == ST_ON);
    end

`ifdef HWAG_SCHED_IRQ_EN
    // Events are gathered over one full scan and reported once at the end
    // of that scan. Matches on the same angle therefore merge into one pulse.
    // Stopping the engine flushes whatever was gathered so far.
    logic r_evt_acc;
    logic r_evt;
    logic w_flush;

    assign w_flush = ~hwag_start | (r_scan == SW'(NCH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt_acc <= 1'b0;
            r_evt     <= 1'b0;
        end else begin
            r_evt_acc <= w_flush ? 1'b0 : (r_evt_acc | w_evt_now);
            r_evt     <= w_flush & (r_evt_acc | w_evt_now);
        end
    end

    assign evt_if = r_evt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_evt_now;
    assign evt_if       = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_event_scheduler.sv
module tb_hwag_event_scheduler;

    localparam int NCH = 4;
    localparam int AW  = 12;
`ifdef HWAG_SCHED_IRQ_EN
    localparam int EXP_EVT = 1;
`else
    localparam int EXP_EVT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           hwag_start = 1'b0;
    logic [AW-1:0]  acnt = '0;
    logic           acnt_e_top = 1'b0;
    logic           we = 1'b0;
    logic [4:0]     addr = '0;
    logic [15:0]    wdata = '0;
    logic [NCH-1:0] ch_out;
    logic           evt_if;

    int n_assert = 0;
    int n_fail   = 0;
    int evt_cnt  = 0;
    int evt_base = 0;

    hwag_event_scheduler #(.NCH(NCH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .hwag_start (hwag_start),
        .acnt       (acnt),
        .acnt_e_top (acnt_e_top),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .ch_out     (ch_out),
        .evt_if     (evt_if)
    );

    always #5 clk = ~clk;

    // Counts clocks during which evt_if is high.
    always @(negedge clk) if (evt_if === 1'b1) evt_cnt <= evt_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every step uses a multiple of 4 clocks. Because of this, each new angle
    // is presented when the scan index is at 0.
    task automatic hold(input int v, input int n4);
        acnt = AW'(v);
        repeat (4 * n4) tick();
    endtask

    task automatic wr(input int a, input int d);
        we = 1'b1; addr = 5'(a); wdata = 16'(d);
        tick();
        we = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wrap();
        acnt = '0; acnt_e_top = 1'b1;
        tick();
        acnt_e_top = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wrap_wr(input int a, input int d);
        acnt = '0; acnt_e_top = 1'b1;
        we = 1'b1; addr = 5'(a); wdata = 16'(d);
        tick();
        acnt_e_top = 1'b0; we = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_ch_out", 32'(ch_out), 0);
        check("rst_evt", 32'(evt_if), 0);
        check("rst_scan", 32'(dut.r_scan), 0);
        rst = 1'b1;
        tick();

        // Test 1: basic on/off on channel 0
        wr(0, 100); wr(1, 200); wr(16, 1);
        wrap();
        hwag_start = 1'b1;
        hold(50, 2);
        check("t1_before_on", 32'(ch_out), 0);
        hold(100, 1);
        check("t1_on_at_100", 32'(ch_out), 1);
        hold(100, 1);
        hold(150, 2);
        check("t1_hold_on", 32'(ch_out), 1);
        hold(200, 1);
        check("t1_off_at_200", 32'(ch_out), 0);
        hold(200, 1);

        // Test 2: shadow off-angle applies only after the next wrap
        wrap();
        hold(100, 2);
        check("t2_on", 32'(ch_out), 1);
        hold(150, 1);
        wr(1, 300);
        hold(150, 1);
        hold(200, 1);
        check("t2_old_off_200", 32'(ch_out), 0);
        hold(300, 1);
        wrap();
        hold(100, 2);
        check("t2_on_again", 32'(ch_out), 1);
        hold(200, 2);
        check("t2_new_off_ignores_200", 32'(ch_out), 1);
        hold(300, 1);
        check("t2_off_at_300", 32'(ch_out), 0);
        // A write on the wrap clock reaches only the shadow register.
        wrap_wr(0, 700);
        hold(100, 1);
        check("t2_wrapwr_old_on", 32'(ch_out), 1);
        hold(300, 1);
        check("t2_wrapwr_off", 32'(ch_out), 0);
        wrap();
        hold(100, 1);
        check("t2_new_on_not_100", 32'(ch_out), 0);
        hold(700, 1);
        check("t2_new_on_700", 32'(ch_out), 1);
        hold(300, 1);
        check("t2_off_300_b", 32'(ch_out), 0);

        // Test 3: equal angles and out-of-range angle
        wr(2, 500); wr(3, 500); wr(4, 4000); wr(5, 600); wr(16, 7);
        wrap();
        evt_base = evt_cnt;
        hold(499, 2);
        hold(500, 2);
        check("t3_eq_at_500", 32'(ch_out), 0);
        hold(501, 2);
        check("t3_eq_after", 32'(ch_out), 0);
        hold(4000, 2);
        check("t3_big_no_match", 32'(ch_out), 0);
        check("t3_big_stored", 32'(dut.r_on[2]), 4000);
        hold(3839, 1);
        wrap();
        hold(500, 2);
        check("t3_eq_next_rev", 32'(ch_out), 0);
        check("t3_no_evt", 32'(evt_cnt - evt_base), 0);

        // Test 4: dropping hwag_start forces all channels off
        wr(4, 1500); wr(5, 1600);
        wrap();
        hold(1500, 2);
        check("t4_ch2_on", 32'(ch_out), 4);
        tick();
        hwag_start = 1'b0;
        tick();
        check("t4_stop_off", 32'(ch_out), 0);
        check("t4_stop_scan", 32'(dut.r_scan), 0);

        // Test 5: asynchronous reset between clock edges
        tick();
        hwag_start = 1'b1;
        hold(700, 2);
        hold(1500, 2);
        check("t5_on_before_rst", 32'(ch_out), 5);
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_off", 32'(ch_out), 0);
        check("t5_async_evt", 32'(evt_if), 0);
        tick();
        tick();
        rst = 1'b1;
        hwag_start = 1'b0;
        tick();
        check("t5_post_ch_out", 32'(ch_out), 0);
        check("t5_post_on0", 32'(dut.r_on[0]), 0);
        check("t5_post_off3", 32'(dut.r_off[3]), 0);
        check("t5_post_shon2", 32'(dut.r_sh_on[2]), 0);
        check("t5_post_mask", 32'(dut.r_mask), 0);

        // Test 6: same on-angle on two channels gives at most one event pulse
        wr(0, 1000); wr(1, 1100); wr(6, 1000); wr(7, 1100); wr(16, 9);
        evt_base = evt_cnt;
        hwag_start = 1'b1;
        hold(999, 2);
        check("t6_before", 32'(ch_out), 0);
        hold(1000, 2);
        check("t6_both_on", 32'(ch_out), 9);
        check("t6_one_pulse", 32'(evt_cnt - evt_base), 32'(EXP_EVT));
        hold(1100, 2);
        check("t6_both_off", 32'(ch_out), 0);
        check("t6_second_pulse", 32'(evt_cnt - evt_base), 32'(2 * EXP_EVT));

        // Clearing an enable bit drops an active channel without an event
        hold(1000, 2);
        check("t6_on_again", 32'(ch_out), 9);
        wr(16, 1);
        wrap();
        check("t6_mask_clear", 32'(ch_out), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hwag_event_scheduler.md
HWAG_EVENT_SCHEDULER -- requirements
Module: hwag_event_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 4, number of output channels; legal values 2..8.
REQ-002 The block SHALL have parameter AW, default 12, angle width; it holds 0..3839.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port hwag_start, input, 1, synchronised-engine flag.
REQ-006 The block SHALL have port acnt, input, AW, current crank angle (ACNT2 value).
REQ-007 The block SHALL have port acnt_e_top, input, 1, one-cycle pulse at angle wrap (3839->0).
REQ-008 The block SHALL have port we, input, 1, configuration write strobe.
REQ-009 The block SHALL have port addr, input, 5, configuration address.
REQ-010 The block SHALL have port wdata, input, 16, configuration write data.
REQ-011 The block SHALL have port ch_out, output, NCH, channel drive outputs.
REQ-012 The block SHALL have port evt_if, output, 1, event pulse (see Configuration).

Function
REQ-013 Address 2k SHALL write the shadow on-angle of channel k (wdata[AW-1:0]); 2k+1 SHALL write the shadow off-angle; address 16 SHALL write the shadow enable mask (wdata[NCH-1:0]); other addresses SHALL be ignored.
REQ-014 Shadow registers SHALL copy into active registers on the clock where acnt_e_top=1 or hwag_start=0; a write in that same cycle SHALL land in shadow only and apply at the next copy.
REQ-015 A scan index SHALL cycle 0..NCH-1, advancing once per clock while hwag_start=1, wrapping NCH-1->0, and holding 0 while hwag_start=0.
REQ-016 Each channel SHALL have a two-state FSM, OFF and ON, evaluated only on clocks where scan index equals its number.
REQ-017 OFF->ON SHALL occur when the channel is enabled and acnt equals its active on-angle; ON->OFF SHALL occur when acnt equals its active off-angle.
REQ-018 When on-angle equals off-angle, the channel SHALL remain OFF.
REQ-019 ch_out[k] SHALL be registered, equal 1 exactly in ON, and update on the clock edge that ends the scan cycle where the transition is detected (latency 1).
REQ-020 Clearing an enable bit (once active) SHALL force that channel to OFF on the next scan of it.
REQ-021 hwag_start=0 SHALL force all channels to OFF on the next clock edge, regardless of the scan index.
REQ-022 Angle values >3839 SHALL be stored but never match.
REQ-023 Correct operation SHALL require acnt to hold each value for at least NCH clocks; faster angle rates MAY miss events, with no other side effect.

Reset
REQ-024 While rst=0, all shadow and active angles SHALL be 0, masks 0, scan index 0, all FSMs OFF, ch_out=0, and evt_if=0.
REQ-025 Assertion of rst mid-operation SHALL take effect immediately, without waiting for a clock edge.

Configuration
REQ-026 With macro HWAG_SCHED_IRQ_EN defined, evt_if SHALL pulse high for exactly one clock after any channel FSM transition caused by an angle match; simultaneous transitions SHALL produce one pulse.
REQ-027 Without HWAG_SCHED_IRQ_EN, evt_if SHALL be tied to 0 and no pulse logic SHALL be synthesised.

Verification
REQ-028 Test 1 SHALL cover basic operation: NCH=4; ch0 on=100, off=200, mask=1, then wrap, hwag_start=1; acnt ramp holding each value 8 clocks -> ch_out[0] rises ≤5 clocks after acnt=100 and falls ≤5 clocks after acnt=200.
REQ-029 Test 2 SHALL cover the shadow timing: while ON, write ch0 off=300 at acnt=150 -> still falls at 200 this revolution; falls at 300 after next acnt_e_top.
REQ-030 Test 3 SHALL cover equal angles: ch1 on=off=500 -> ch_out[1] stays 0 for a full revolution, and evt_if never pulses for ch1.
REQ-031 Test 4 SHALL cover the stop condition: ch2 ON, then drop hwag_start -> ch_out=0 on next edge and scan index reads 0.
REQ-032 Test 5 SHALL cover reset: assert rst low between clock edges while channels are ON -> ch_out=0 immediately; after release, all channels OFF and angles 0.
REQ-033 Test 6 SHALL cover the macro: with HWAG_SCHED_IRQ_EN, ch0 and ch3 both set on=1000 -> one single-cycle evt_if pulse; without the macro, evt_if stays 0 throughout.
